stage_4_mem: RTL and testbench

Memory-access pipeline stage. It consumes the execute-stage result bundle (ALU result, rs_2 store data, rd number, opcode, func_3, op_type) and runs loads and stores against the data memory over a valid/ready request interface. It also passes non-memory results through to writeback. It stalls upstream while a memory transaction is outstanding.

---
 rtl/stage_4_mem_pkg.sv | 54 +++++
 rtl/stage_4_mem_if.sv | 15 +
 rtl/stage_4_mem_lsu_align.sv | 64 ++++++
 rtl/stage_4_mem.sv | 147 ++++++++++++++
 tb/tb_stage_4_mem.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_4_mem_pkg.sv
// Shared types and encodings for the memory-access pipeline stage.
// Holds func_3 codes, opcodes, FSM states, the registered-state bundle and small helpers.
package stage_4_mem_pkg;

    typedef enum logic {
        S4_IDLE,
        S4_REQ
    } s4_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
        logic        is_store;
        logic [2:0]  func3;
        logic [1:0]  addr_lo;
        logic [4:0]  rd;
        logic        o_valid;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        misalign;
        logic        bus_err;
    } s4_regs_t;

    function automatic logic [31:0] sign_extend(input logic [15:0] v, input logic is_half);
        sign_extend = is_half ? {{16{v[15]}}, v} : {{24{v[7]}}, v[7:0]};
    endfunction

    function automatic logic writes_rd(input logic [6:0] opc);
        writes_rd = opc inside {OPC_OPIMM, OPC_OP, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
    endfunction

endpackage

// File: rtl/stage_4_mem_if.sv
// Data-memory request bus: valid/ready request with registered address, data and strobes.
interface stage_4_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                    output mem_ready, mem_rdata);
endinterface

// File: rtl/stage_4_mem_lsu_align.sv
// Combinational load/store lane logic: legality/alignment check, store replication
// and strobes, and load lane extraction with sign/zero extension.
module lsu_align
    import stage_4_mem_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  func3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rs2_i,
    output logic        legal_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    input  logic [2:0]  ld_func3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic        f3_ok;
    logic        aligned;
    logic [31:0] shifted;

    always_comb begin
        f3_ok   = is_store_i ? (func3_i inside {SB, SH, SW})
                             : (func3_i inside {LB, LH, LW, LBU, LHU});
        case (func3_i[1:0])
            2'b01:   aligned = !addr_lo_i[0];
            2'b10:   aligned = (addr_lo_i == 2'b00);
            default: aligned = 1'b1;
        endcase
        legal_o = f3_ok && aligned;

        wdata_o = '0;
        wstrb_o = '0;
        if (is_store_i) begin
            case (func3_i[1:0])
                2'b00: begin
                    wdata_o = {4{rs2_i[7:0]}};
                    wstrb_o = 4'b0001 << addr_lo_i;
                end
                2'b01: begin
                    wdata_o = {2{rs2_i[15:0]}};
                    wstrb_o = 4'b0011 << addr_lo_i;
                end
                default: begin
                    wdata_o = rs2_i;
                    wstrb_o = '1;
                end
            endcase
        end
    end

    always_comb begin
        shifted = rdata_i >> {ld_addr_lo_i, 3'b000};
        case (ld_func3_i)
            LB:      ld_data_o = sign_extend(shifted[15:0], 1'b0);
            LH:      ld_data_o = sign_extend(shifted[15:0], 1'b1);
            LBU:     ld_data_o = {24'd0, shifted[7:0]};
            LHU:     ld_data_o = {16'd0, shifted[15:0]};
            default: ld_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/stage_4_mem.sv
// Memory-access pipeline stage: passes ALU results through, runs loads/stores over
// the request bus, stalls upstream while a request is outstanding, flags timeouts.
module stage_4_mem
    import stage_4_mem_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_valid,
    input  logic [31:0]          i_alu_out,
    input  logic [31:0]          i_rs_2,
    input  logic [4:0]           i_rd_num,
    input  logic [6:0]           i_opcode,
    input  logic [2:0]           i_func_3,
    input  logic                 i_op_type,
    output logic                 stall,
    stage_4_mem_if.master        mem,
    output logic                 o_valid,
    output logic                 wb_en,
    output logic [4:0]           wb_rd_num,
    output logic [31:0]          wb_data,
    output logic                 misalign,
    output logic                 bus_err
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

    s4_state_t      state_q, state_d;
    s4_regs_t       r_q, r_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           in_store;
    logic           legal;
    logic [31:0]    st_wdata;
    logic [3:0]     st_wstrb;
    logic [31:0]    ld_data;
    logic           timed_out;

    assign in_store  = (i_opcode == OPC_STORE);
    assign timed_out = !mem.mem_ready && (cnt_q == CW'(MEM_TIMEOUT - 1));

    lsu_align u_lsu_align (
        .is_store_i   (in_store),
        .func3_i      (i_func_3),
        .addr_lo_i    (i_alu_out[1:0]),
        .rs2_i        (i_rs_2),
        .legal_o      (legal),
        .wdata_o      (st_wdata),
        .wstrb_o      (st_wstrb),
        .ld_func3_i   (r_q.func3),
        .ld_addr_lo_i (r_q.addr_lo),
        .rdata_i      (mem.mem_rdata),
        .ld_data_o    (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S4_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S4_IDLE: if (i_valid && i_op_type && legal) state_d = S4_REQ;
            S4_REQ:  if (mem.mem_ready || timed_out)    state_d = S4_IDLE;
            default: state_d = S4_IDLE;
        endcase
    end

    // Pulse outputs default low each cycle; wb_data/wb_rd_num hold unless a result lands.
    always_comb begin
        r_d          = r_q;
        r_d.o_valid  = 1'b0;
        r_d.wb_en    = 1'b0;
        r_d.misalign = 1'b0;
        r_d.bus_err  = 1'b0;
        cnt_d        = cnt_q;
        stall        = (state_q == S4_REQ);
        case (state_q)
            S4_IDLE: begin
                cnt_d = '0;
                if (i_valid && !i_op_type) begin
                    r_d.o_valid = 1'b1;
                    r_d.wb_data = i_alu_out;
                    r_d.wb_rd   = i_rd_num;
                    r_d.wb_en   = (i_rd_num != 5'd0) && writes_rd(i_opcode);
                end else if (i_valid && !legal) begin
                    r_d.o_valid  = 1'b1;
                    r_d.misalign = 1'b1;
                end else if (i_valid) begin
                    r_d.mem_req   = 1'b1;
                    r_d.mem_we    = in_store;
                    r_d.mem_addr  = {i_alu_out[31:2], 2'b00};
                    r_d.mem_wdata = st_wdata;
                    r_d.mem_wstrb = st_wstrb;
                    r_d.is_store  = in_store;
                    r_d.func3     = i_func_3;
                    r_d.addr_lo   = i_alu_out[1:0];
                    r_d.rd        = i_rd_num;
                end
            end
            S4_REQ: begin
                if (mem.mem_ready || timed_out) begin
                    r_d.mem_req   = 1'b0;
                    r_d.mem_we    = 1'b0;
                    r_d.mem_wstrb = '0;
                    r_d.o_valid   = 1'b1;
                    cnt_d         = '0;
                    if (!mem.mem_ready) begin
                        r_d.bus_err = 1'b1;
                    end else if (!r_q.is_store) begin
                        r_d.wb_en   = (r_q.rd != 5'd0);
                        r_d.wb_data = ld_data;
                        r_d.wb_rd   = r_q.rd;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q   <= '0;
            cnt_q <= '0;
        end else begin
            r_q   <= r_d;
            cnt_q <= cnt_d;
        end
    end

    assign mem.mem_req   = r_q.mem_req;
    assign mem.mem_we    = r_q.mem_we;
    assign mem.mem_addr  = r_q.mem_addr;
    assign mem.mem_wdata = r_q.mem_wdata;
    assign mem.mem_wstrb = r_q.mem_wstrb;
    assign o_valid       = r_q.o_valid;
    assign wb_en         = r_q.wb_en;
    assign wb_rd_num     = r_q.wb_rd;
    assign wb_data       = r_q.wb_data;
    assign misalign      = r_q.misalign;
    assign bus_err       = r_q.bus_err;

endmodule

// File: tb/tb_stage_4_mem.sv
// Self-checking bench for stage_4_mem: directed scenarios plus a randomized
// back-to-back stream checked against a byte-level reference model.
module tb_stage_4_mem;

    localparam logic [6:0] T_LOAD  = 7'b0000011;
    localparam logic [6:0] T_STORE = 7'b0100011;
    localparam logic [6:0] T_OPIMM = 7'b0010011;
    localparam logic [6:0] T_BRNCH = 7'b1100011;

    typedef struct packed {
        logic        ovalid;
        logic        wb_en;
        logic        misalign;
        logic        bus_err;
        logic        unstable;
        logic        stall_done;
        logic        req_done;
        logic        we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          req_cycles;
        int          stall_cycles;
        int          lat;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_alu_out = '0;
    logic [31:0] i_rs_2 = '0;
    logic [4:0]  i_rd_num = '0;
    logic [6:0]  i_opcode = '0;
    logic [2:0]  i_func_3 = '0;
    logic        i_op_type = 1'b0;
    logic        stall, o_valid, wb_en, misalign, bus_err;
    logic [4:0]  wb_rd_num;
    logic [31:0] wb_data;
    int          checks = 0;
    int          errors = 0;

    stage_4_mem_if mif ();

    stage_4_mem #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_alu_out(i_alu_out),
        .i_rs_2(i_rs_2), .i_rd_num(i_rd_num), .i_opcode(i_opcode), .i_func_3(i_func_3),
        .i_op_type(i_op_type), .stall(stall), .mem(mif), .o_valid(o_valid),
        .wb_en(wb_en), .wb_rd_num(wb_rd_num), .wb_data(wb_data),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: architectural rules expressed with plain arithmetic.
    function automatic logic ref_wb(input logic [6:0] opc);
        logic [6:0] list [6] = '{7'h13, 7'h33, 7'h6F, 7'h67, 7'h37, 7'h17};
        ref_wb = 1'b0;
        foreach (list[k]) if (list[k] == opc) ref_wb = 1'b1;
    endfunction

    function automatic logic ref_legal(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        int nbytes = 1 << f3[1:0];
        logic ok = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        ref_legal = ok && ((addr % nbytes) == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        int nbytes = 1 << f3[1:0];
        logic [31:0] v = rdata >> (8 * addr[1:0]);
        logic [31:0] mask;
        if (nbytes < 4) begin
            mask = (32'd1 << (8 * nbytes)) - 32'd1;
            v = v & mask;
            if (!f3[2] && v[8 * nbytes - 1]) v = v | ~mask;
        end
        ref_load = v;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        if (f3[1:0] == 2'd0)      ref_wdata = {24'd0, rs2[7:0]} * 32'h01010101;
        else if (f3[1:0] == 2'd1) ref_wdata = {16'd0, rs2[15:0]} * 32'h00010001;
        else                      ref_wdata = rs2;
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic [2:0] f3, input logic [31:0] addr);
        int nbytes = 1 << f3[1:0];
        ref_wstrb = 4'(((1 << nbytes) - 1) << addr[1:0]);
    endfunction

    task automatic run_alu(input logic [6:0] opc, input logic [31:0] alu, input logic [4:0] rd,
                           output logic ov, output logic we, output logic st,
                           output logic [4:0] wrd, output logic [31:0] wd);
        i_valid = 1'b1; i_op_type = 1'b0; i_opcode = opc; i_alu_out = alu; i_rd_num = rd;
        i_func_3 = 3'($urandom); i_rs_2 = $urandom;
        step();
        i_valid = 1'b0;
        ov = o_valid; we = wb_en; st = stall; wrd = wb_rd_num; wd = wb_data;
    endtask

    // Drives one memory op and acts as the memory; ready comes after `delay` waiting REQ cycles.
    task automatic run_mem(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rs2, input logic [4:0] rd, input int delay,
                           input logic [31:0] rdata, output obs_t o);
        logic seen = 1'b0;
        o = '0;
        mif.mem_ready = 1'b0;
        i_valid = 1'b1; i_op_type = 1'b1; i_opcode = st ? T_STORE : T_LOAD;
        i_func_3 = f3; i_alu_out = addr; i_rs_2 = rs2; i_rd_num = rd;
        step();
        o.lat = 1;
        i_valid = 1'b0; i_alu_out = $urandom; i_rs_2 = $urandom; i_func_3 = 3'($urandom);
        for (int c = 0; c < 64 && !o_valid; c++) begin
            if (mif.mem_req) begin
                if (!seen) begin
                    o.addr = mif.mem_addr; o.wdata = mif.mem_wdata;
                    o.wstrb = mif.mem_wstrb; o.we = mif.mem_we; seen = 1'b1;
                end else if ({o.addr, o.wdata, o.wstrb, o.we} !==
                             {mif.mem_addr, mif.mem_wdata, mif.mem_wstrb, mif.mem_we}) begin
                    o.unstable = 1'b1;
                end
                o.req_cycles++;
            end
            if (stall) o.stall_cycles++;
            mif.mem_ready = mif.mem_req && (o.req_cycles > delay);
            mif.mem_rdata = mif.mem_ready ? rdata : $urandom;
            step();
            o.lat++;
        end
        mif.mem_ready = 1'b0;
        o.ovalid = o_valid; o.wb_en = wb_en; o.misalign = misalign; o.bus_err = bus_err;
        o.wb_rd = wb_rd_num; o.wb_data = wb_data; o.stall_done = stall; o.req_done = mif.mem_req;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mif.mem_ready = 1'b0; mif.mem_rdata = '0;
        step();
        i_valid = 1'b1; i_op_type = 1'b0; i_opcode = T_OPIMM; i_alu_out = 32'hDEAD; i_rd_num = 5'd3;
        step();
        i_valid = 1'b0;
        checks++;
        if ({stall, o_valid, wb_en, misalign, bus_err, wb_rd_num, wb_data, mif.mem_req, mif.mem_we,
             mif.mem_addr, mif.mem_wdata, mif.mem_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ov=%b wb_en=%b wb_data=%h req=%b exp all zero",
                     o_valid, wb_en, wb_data, mif.mem_req);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu_passthrough();
        logic ov, we, st;
        logic [4:0] wrd;
        logic [31:0] wd;
        run_alu(T_OPIMM, 32'h1234, 5'd5, ov, we, st, wrd, wd);
        checks++;
        if ({ov, we, st, wrd, wd} !== {1'b1, 1'b1, 1'b0, 5'd5, 32'h1234}) begin
            errors++;
            $display("FAIL addi_rd5 got ov=%b we=%b stall=%b rd=%0d data=%h exp 1 1 0 5 00001234", ov, we, st, wrd, wd);
        end
        step();
        checks++;
        if ({o_valid, wb_en} !== 2'b00) begin
            errors++;
            $display("FAIL addi_pulse got ov=%b we=%b exp 0 0", o_valid, wb_en);
        end
        run_alu(T_OPIMM, 32'h5678, 5'd0, ov, we, st, wrd, wd);
        checks++;
        if ({ov, we, st, wd} !== {1'b1, 1'b0, 1'b0, 32'h5678}) begin
            errors++;
            $display("FAIL addi_rd0 got ov=%b we=%b stall=%b data=%h exp 1 0 0 00005678", ov, we, st, wd);
        end
    endtask

    task automatic test_store_byte();
        obs_t o;
        run_mem(1'b1, 3'b000, 32'h1003, 32'h000000AB, 5'd7, 3, $urandom, o);
        checks++;
        if ({o.addr, o.wdata, o.wstrb, o.we} !== {32'h1000, 32'hABABABAB, 4'b1000, 1'b1}) begin
            errors++;
            $display("FAIL sb_bus got addr=%h wdata=%h wstrb=%b we=%b exp 00001000 abababab 1000 1",
                     o.addr, o.wdata, o.wstrb, o.we);
        end
        checks++;
        if ({o.stall_cycles, o.req_cycles, o.unstable} !== {32'd4, 32'd4, 1'b0}) begin
            errors++;
            $display("FAIL sb_hold got stall=%0d req=%0d unstable=%b exp 4 4 0", o.stall_cycles, o.req_cycles, o.unstable);
        end
        checks++;
        if ({o.ovalid, o.wb_en, o.bus_err, o.req_done, o.stall_done} !== 5'b10000) begin
            errors++;
            $display("FAIL sb_done got ov=%b we=%b berr=%b req=%b stall=%b exp 1 0 0 0 0",
                     o.ovalid, o.wb_en, o.bus_err, o.req_done, o.stall_done);
        end
    endtask

    task automatic test_loads();
        obs_t o;
        logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b001};
        logic [31:0] exps [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00000080};
        foreach (f3s[k]) begin
            run_mem(1'b0, f3s[k], 32'h2002, $urandom, 5'd9, 0, 32'h0080FF00, o);
            checks++;
            if ({o.ovalid, o.wb_en, o.wb_rd, o.wb_data, o.lat} !== {1'b1, 1'b1, 5'd9, exps[k], 32'd2}) begin
                errors++;
                $display("FAIL load_f3_%0d got ov=%b we=%b rd=%0d data=%h lat=%0d exp 1 1 9 %h 2",
                         f3s[k], o.ovalid, o.wb_en, o.wb_rd, o.wb_data, o.lat, exps[k]);
            end
        end
    endtask

    task automatic test_misalign();
        obs_t o;
        run_mem(1'b0, 3'b001, 32'h2001, '0, 5'd4, 0, $urandom, o);
        checks++;
        if ({o.ovalid, o.misalign, o.wb_en, o.req_cycles, o.lat} !== {3'b110, 32'd0, 32'd1}) begin
            errors++;
            $display("FAIL lh_misalign got ov=%b mis=%b we=%b req=%0d lat=%0d exp 1 1 0 0 1",
                     o.ovalid, o.misalign, o.wb_en, o.req_cycles, o.lat);
        end
        run_mem(1'b0, 3'b011, 32'h2000, '0, 5'd4, 0, $urandom, o);
        checks++;
        if ({o.ovalid, o.misalign, o.wb_en, o.req_cycles, o.lat} !== {3'b110, 32'd0, 32'd1}) begin
            errors++;
            $display("FAIL illegal_f3 got ov=%b mis=%b we=%b req=%0d lat=%0d exp 1 1 0 0 1",
                     o.ovalid, o.misalign, o.wb_en, o.req_cycles, o.lat);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        logic ov, we, st;
        logic [4:0] wrd;
        logic [31:0] wd;
        run_mem(1'b0, 3'b010, 32'h3000, '0, 5'd6, 1000, $urandom, o);
        checks++;
        if ({o.req_cycles, o.ovalid, o.bus_err, o.wb_en, o.stall_done, o.req_done} !== {32'd4, 5'b11000}) begin
            errors++;
            $display("FAIL timeout got req=%0d ov=%b berr=%b we=%b stall=%b req_done=%b exp 4 1 1 0 0 0",
                     o.req_cycles, o.ovalid, o.bus_err, o.wb_en, o.stall_done, o.req_done);
        end
        run_alu(T_OPIMM, 32'hCAFE, 5'd2, ov, we, st, wrd, wd);
        checks++;
        if ({ov, we, wd} !== {2'b11, 32'hCAFE}) begin
            errors++;
            $display("FAIL after_timeout got ov=%b we=%b data=%h exp 1 1 0000cafe", ov, we, wd);
        end
    endtask

    task automatic test_reset_mid_txn();
        int stray = 0;
        mif.mem_ready = 1'b0;
        i_valid = 1'b1; i_op_type = 1'b1; i_opcode = T_STORE; i_func_3 = 3'b010;
        i_alu_out = 32'h4000; i_rs_2 = $urandom; i_rd_num = 5'd0;
        step();
        i_valid = 1'b0;
        step();
        checks++;
        if ({mif.mem_req, stall} !== 2'b11) begin
            errors++;
            $display("FAIL sw_second_req got req=%b stall=%b exp 1 1", mif.mem_req, stall);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({stall, o_valid, wb_en, misalign, bus_err, wb_rd_num, wb_data, mif.mem_req, mif.mem_we,
             mif.mem_addr, mif.mem_wdata, mif.mem_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_mid got req=%b stall=%b ov=%b addr=%h exp all zero", mif.mem_req, stall, o_valid, mif.mem_addr);
        end
        mif.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (o_valid) stray++;
        end
        mif.mem_ready = 1'b0;
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL reset_stray_ovalid got %0d exp 0", stray);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] alu_opcs [8] = '{7'h13, 7'h33, 7'h6F, 7'h67, 7'h37, 7'h17, T_BRNCH, 7'h73};
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                logic ov, we, st;
                logic [4:0] wrd;
                logic [31:0] wd;
                logic [6:0] opc = alu_opcs[$urandom_range(0, 7)];
                logic [31:0] alu = $urandom;
                logic [4:0] rd = 5'($urandom);
                mif.mem_ready = 1'($urandom);
                run_alu(opc, alu, rd, ov, we, st, wrd, wd);
                mif.mem_ready = 1'b0;
                checks++;
                if ({ov, we, st, wrd, wd} !== {1'b1, ref_wb(opc) && rd != 0, 1'b0, rd, alu}) begin
                    errors++;
                    $display("FAIL rnd_alu_%0d opc=%h got ov=%b we=%b st=%b rd=%0d data=%h", n, opc, ov, we, st, wrd, wd);
                end
            end else begin
                obs_t o;
                logic st = 1'($urandom);
                logic [2:0] f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
                logic [31:0] addr = $urandom;
                logic [31:0] rs2 = $urandom;
                logic [31:0] rdata = $urandom;
                logic [4:0] rd = 5'($urandom);
                int delay = $urandom_range(0, 3);
                logic legal;
                if (!st && $urandom_range(0, 1) == 1) f3[2] = f3[1:0] != 2'd2 ? 1'b1 : 1'b0;
                if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
                legal = ref_legal(st, f3, addr);
                run_mem(st, f3, addr, rs2, rd, delay, rdata, o);
                checks++;
                if (!legal) begin
                    if ({o.ovalid, o.misalign, o.wb_en, o.bus_err, o.req_cycles, o.lat} !== {4'b1100, 32'd0, 32'd1}) begin
                        errors++;
                        $display("FAIL rnd_mis_%0d f3=%0d addr=%h got ov=%b mis=%b we=%b req=%0d lat=%0d",
                                 n, f3, addr, o.ovalid, o.misalign, o.wb_en, o.req_cycles, o.lat);
                    end
                end else if ({o.ovalid, o.misalign, o.bus_err, o.unstable, o.lat, o.addr, o.we, o.wstrb} !==
                             {4'b1000, 32'(delay + 2), addr & ~32'd3, st, st ? ref_wstrb(f3, addr) : 4'd0}) begin
                    errors++;
                    $display("FAIL rnd_bus_%0d st=%b f3=%0d addr=%h got ov=%b lat=%0d maddr=%h we=%b wstrb=%b uns=%b",
                             n, st, f3, addr, o.ovalid, o.lat, o.addr, o.we, o.wstrb, o.unstable);
                end
                if (legal) begin
                    checks++;
                    if (st && {o.wdata, o.wb_en} !== {ref_wdata(f3, rs2), 1'b0}) begin
                        errors++;
                        $display("FAIL rnd_store_%0d f3=%0d got wdata=%h we=%b exp %h 0", n, f3, o.wdata, o.wb_en, ref_wdata(f3, rs2));
                    end else if (!st && {o.wb_en, o.wb_rd, o.wb_data} !== {rd != 0, rd, ref_load(f3, addr, rdata)}) begin
                        errors++;
                        $display("FAIL rnd_load_%0d f3=%0d addr=%h rdata=%h got we=%b rd=%0d data=%h exp %h",
                                 n, f3, addr, rdata, o.wb_en, o.wb_rd, o.wb_data, ref_load(f3, addr, rdata));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_passthrough();
        test_store_byte();
        test_loads();
        test_misalign();
        test_timeout();
        test_reset_mid_txn();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
